candd_output_sequencer: RTL
===========================

CANDD_OUTPUT_SEQUENCER -- requirements
Module: candd_output_sequencer

Interface
REQ-001 Parameter RESET_HOLD_CYCLES, default 16, SHALL set the clk cycles clkReset is held in HOLD (legal 2..255).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for async status inputs (legal 2..4).
REQ-003 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; assertion SHALL act immediately, deassertion is sampled by clk.
REQ-005 clkEnIn  in  1  symbol strobe, synchronous to clk.
REQ-006 dllPhaseError  in  8  signed two's-complement DLL phase error, synchronous to clk.
REQ-007 pllLocked  in  1  external PLL lock pin, asynchronous.
REQ-008 dllFull, dllEmpty, pllFull, pllEmpty  in  1 each  jitter-FIFO flags, asynchronous.
REQ-009 restart  in  1  single-cycle request to re-run the sequence.
REQ-010 lockThreshold  in  7  maximum |dllPhaseError| counted as in-lock.
REQ-011 lockCount  in  8  consecutive in-lock symbols required to declare lock; 0 is treated as 1.
REQ-012 timeoutSymbols  in  16  symbols allowed in WAIT_DLL before retry; 0 disables the timeout.
REQ-013 preferPll  in  1  allow promotion to the external PLL path.
REQ-014 clkReset  out  1  reset to the DLL and both FIFOs.
REQ-015 dllSelect  out  1  final output mux select; 1 = DLL path.
REQ-016 state  out  3  current state encoding.
REQ-017 faultCount  out  8  saturating count of FAULT entries.

Function
REQ-018 The FSM SHALL use these encodings: HOLD=0, WAIT_DLL=1, DLL_RUN=2, WAIT_PLL=3, PLL_RUN=4, FAULT=5.
REQ-019 HOLD SHALL assert clkReset for RESET_HOLD_CYCLES cycles, then enter WAIT_DLL; clkReset SHALL be 0 in every other state.
REQ-020 In WAIT_DLL, each clkEnIn with |dllPhaseError| <= lockThreshold SHALL increment the lock counter; a clkEnIn outside the threshold SHALL clear it.
REQ-021 Abs-value rule: |-128| SHALL be taken as 128, so it is never <= any 7-bit threshold.
REQ-022 Reaching lockCount SHALL move the FSM to DLL_RUN on the next cycle.
REQ-023 In WAIT_DLL, timeoutSymbols nonzero symbols without lock SHALL move the FSM to HOLD; faultCount SHALL be unchanged.
REQ-024 In DLL_RUN, when preferPll=1 and synced pllLocked=1, the FSM SHALL enter WAIT_PLL.
REQ-025 In WAIT_PLL, lockCount consecutive symbols with pllLocked=1 SHALL move the FSM to PLL_RUN; pllLocked=0 or preferPll=0 SHALL return it to DLL_RUN.
REQ-026 In PLL_RUN, synced pllLocked=0 or preferPll=0 SHALL return the FSM to DLL_RUN in one cycle.
REQ-027 dllSelect SHALL be 0 only in PLL_RUN, registered, and change on the cycle after the state change.
REQ-028 The active-path FIFO flags (DLL flags in DLL_RUN and WAIT_PLL, PLL flags in PLL_RUN) SHALL be armed 4 symbols after run entry; a synced full or empty while armed SHALL enter FAULT.
REQ-029 FAULT SHALL last one cycle, increment faultCount (saturating at 255), then enter HOLD.
REQ-030 restart SHALL force HOLD from any state next cycle and SHALL take priority over all other transitions; it SHALL NOT count as a fault.
REQ-031 A fault and a PLL loss in the same cycle SHALL resolve to FAULT.

Reset
REQ-032 On reset assertion: state=HOLD, clkReset=1, dllSelect=1, faultCount=0, all counters and synchronizers=0.
REQ-033 After deassertion, HOLD SHALL run its full RESET_HOLD_CYCLES count.

Configuration
REQ-034 With CANDD_SEQ_PLL_EN defined, the PLL states and PLL flag monitoring SHALL be present.
REQ-035 Without CANDD_SEQ_PLL_EN, WAIT_PLL and PLL_RUN SHALL be unreachable, dllSelect SHALL be constant 1, and pllLocked, pllFull and pllEmpty SHALL be ignored.

Structure
REQ-036 State encodings and the arming constant (4) SHALL live in a shared package, candd_pkg.
REQ-037 The async inputs SHALL pass through one reusable sub-module, candd_sync, with SYNC_STAGES flops per bit.

Verification
REQ-038 Reset release with lockCount=8, threshold=10, errors ±5 -> 16 clkReset cycles, WAIT_DLL, then DLL_RUN after the 8th symbol.
REQ-039 Error sequence 5,5,20,5x8 with lockCount=8 -> counter clears at 20; DLL_RUN follows the 11th symbol.
REQ-040 preferPll=1, pllLocked held high 8 symbols -> PLL_RUN with dllSelect=0; drop pllLocked -> DLL_RUN and dllSelect=1 within SYNC_STAGES+2 cycles.
REQ-041 dllEmpty pulse 2 symbols after DLL_RUN entry -> ignored; same pulse after 5 symbols -> FAULT, faultCount=1, then HOLD.
REQ-042 timeoutSymbols=100, errors always 50 -> HOLD after 100 symbols; faultCount stays 0.
REQ-043 300 forced faults -> faultCount saturates at 255; restart mid-PLL_RUN -> HOLD next cycle.

Source files
------------

// File: rtl/candd_pkg.sv
// candd_pkg -- shared definitions for the clock-and-data output sequencer.
//   seqState_e   : FSM state encodings (visible on the state output)
//   ARM_SYMBOLS  : symbols after run entry before FIFO flags can fault
//   absErr       : magnitude of a signed 8-bit phase error (|-128| = 128)
package candd_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    WAIT_DLL = 3'd1,
    DLL_RUN  = 3'd2,
    WAIT_PLL = 3'd3,
    PLL_RUN  = 3'd4,
    FAULT    = 3'd5
  } seqState_e;

  localparam int unsigned ARM_SYMBOLS = 4;

  // Unsigned 8-bit result, so -128 maps to 128 and never fits a 7-bit threshold.
  function automatic logic [7:0] absErr(input logic [7:0] e);
    return e[7] ? (~e + 8'd1) : e;
  endfunction

endpackage

// File: rtl/candd_sync.sv
// candd_sync -- multi-bit, per-bit flop synchronizer for asynchronous status pins.
//   clk   : destination clock
//   reset : async active-low, clears every stage
//   d     : asynchronous inputs
//   q     : synchronized outputs, STAGES clk edges later
module candd_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe <= '0;
    else        pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/candd_output_sequencer.sv
// candd_output_sequencer -- bring-up / supervision FSM for the DLL output clock,
// with optional promotion to an external PLL path.
// Optional feature: define CANDD_SEQ_PLL_EN to build the PLL states
// (WAIT_PLL, PLL_RUN) and PLL FIFO flag monitoring.
// Ports:
//   clk, reset            : clock, async active-low reset
//   clkEnIn               : symbol strobe
//   dllPhaseError[7:0]    : signed DLL phase error
//   pllLocked             : async external PLL lock
//   dllFull/dllEmpty      : async DLL jitter-FIFO flags
//   pllFull/pllEmpty      : async PLL jitter-FIFO flags
//   restart               : force HOLD next cycle
//   lockThreshold[6:0]    : max |error| counted as in-lock
//   lockCount[7:0]        : consecutive lock symbols needed (0 acts as 1)
//   timeoutSymbols[15:0]  : WAIT_DLL symbol budget (0 = no timeout)
//   preferPll             : allow PLL promotion
//   clkReset              : DLL/FIFO reset, high only in HOLD
//   dllSelect             : output mux, 1 = DLL path (registered)
//   state[2:0]            : current state
//   faultCount[7:0]       : saturating FAULT entry count
module candd_output_sequencer
  import candd_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int SYNC_STAGES       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEnIn,
  input  logic [7:0]  dllPhaseError,
  input  logic        pllLocked,
  input  logic        dllFull,
  input  logic        dllEmpty,
  input  logic        pllFull,
  input  logic        pllEmpty,
  input  logic        restart,
  input  logic [6:0]  lockThreshold,
  input  logic [7:0]  lockCount,
  input  logic [15:0] timeoutSymbols,
  input  logic        preferPll,
  output logic        clkReset,
  output logic        dllSelect,
  output logic [2:0]  state,
  output logic [7:0]  faultCount
);

  seqState_e curState, nextState;
  logic [7:0]  holdCnt;
  logic [7:0]  lockCnt;   // in-lock symbols (WAIT_DLL) or PLL-locked symbols (WAIT_PLL)
  logic [15:0] toCnt;
  logic [2:0]  armCnt;

  // ---- asynchronous status inputs
  logic dllFullS, dllEmptyS;
`ifdef CANDD_SEQ_PLL_EN
  logic [4:0] syncQ;
  logic pllLockS, pllFullS, pllEmptyS;
  candd_sync #(.WIDTH(5), .STAGES(SYNC_STAGES)) uSync (
    .clk(clk), .reset(reset),
    .d({pllLocked, pllFull, pllEmpty, dllFull, dllEmpty}), .q(syncQ));
  assign {pllLockS, pllFullS, pllEmptyS, dllFullS, dllEmptyS} = syncQ;
`else
  logic [1:0] syncQ;
  logic unusedPll;
  candd_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) uSync (
    .clk(clk), .reset(reset), .d({dllFull, dllEmpty}), .q(syncQ));
  assign {dllFullS, dllEmptyS} = syncQ;
  assign unusedPll = ^{preferPll, pllLocked, pllFull, pllEmpty};
`endif

  // ---- per-symbol qualifiers
  logic [7:0] effLock;
  logic inLock, lockHit, toHit, armed, dllFlag;
  assign effLock = (lockCount == 8'd0) ? 8'd1 : lockCount;
  assign inLock  = absErr(dllPhaseError) <= {1'b0, lockThreshold};
  assign lockHit = inLock && (({1'b0, lockCnt} + 9'd1) == {1'b0, effLock});
  assign toHit   = (timeoutSymbols != 16'd0) &&
                   (({1'b0, toCnt} + 17'd1) == {1'b0, timeoutSymbols});
  assign armed   = (armCnt == 3'(ARM_SYMBOLS));
  assign dllFlag = dllFullS || dllEmptyS;

  always_comb begin
    nextState = curState;
    case (curState)
      HOLD:     if (holdCnt == 8'(RESET_HOLD_CYCLES - 1)) nextState = WAIT_DLL;
      WAIT_DLL: if (clkEnIn) begin
                  if (lockHit)    nextState = DLL_RUN;   // lock wins over a same-symbol timeout
                  else if (toHit) nextState = HOLD;
                end
      DLL_RUN:  if (armed && dllFlag) nextState = FAULT;
`ifdef CANDD_SEQ_PLL_EN
                else if (preferPll && pllLockS) nextState = WAIT_PLL;
      WAIT_PLL: if (armed && dllFlag)              nextState = FAULT;
                else if (!preferPll || !pllLockS)  nextState = DLL_RUN;
                else if (clkEnIn && (({1'b0, lockCnt} + 9'd1) == {1'b0, effLock}))
                                                   nextState = PLL_RUN;
      // Fault checked first so a coincident PLL loss still resolves to FAULT.
      PLL_RUN:  if (armed && (pllFullS || pllEmptyS)) nextState = FAULT;
                else if (!preferPll || !pllLockS)    nextState = DLL_RUN;
`endif
      FAULT:    nextState = HOLD;
      default:  nextState = HOLD;
    endcase
    if (restart) nextState = HOLD;
  end

  // A new run period starts on entering DLL_RUN from outside the DLL path,
  // or on entering PLL_RUN; DLL_RUN <-> WAIT_PLL keeps the DLL arming.
  logic runNext, newRun;
  assign runNext = nextState inside {DLL_RUN, WAIT_PLL, PLL_RUN};
  assign newRun  = (nextState == DLL_RUN && !(curState inside {DLL_RUN, WAIT_PLL})) ||
                   (nextState == PLL_RUN && curState != PLL_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState   <= HOLD;
      holdCnt    <= '0;
      lockCnt    <= '0;
      toCnt      <= '0;
      armCnt     <= '0;
      faultCount <= '0;
    end else begin
      curState <= nextState;
      holdCnt  <= (curState == HOLD && !restart) ? holdCnt + 8'd1 : 8'd0;

      if (nextState != curState)                 lockCnt <= '0;
      else if (clkEnIn && curState == WAIT_DLL)  lockCnt <= inLock ? lockCnt + 8'd1 : 8'd0;
      else if (clkEnIn && curState == WAIT_PLL)  lockCnt <= lockCnt + 8'd1;

      if (nextState != curState)                 toCnt <= '0;
      else if (clkEnIn && curState == WAIT_DLL)  toCnt <= toCnt + 16'd1;

      if (!runNext || newRun)     armCnt <= '0;
      else if (clkEnIn && !armed) armCnt <= armCnt + 3'd1;

      if (nextState == FAULT && curState != FAULT && faultCount != 8'hFF)
        faultCount <= faultCount + 8'd1;
    end
  end

`ifdef CANDD_SEQ_PLL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dllSelect <= 1'b1;
    else        dllSelect <= (curState != PLL_RUN);
  end
`else
  assign dllSelect = 1'b1;
`endif

  assign clkReset = (curState == HOLD);
  assign state    = curState;

endmodule
